mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Parametrised successor to the single-cycle memory stage of the 5-stage pipeline; sits between EX and WB.
- Adds a variable-latency data-memory response handshake: the stage stalls until a load's read data returns.
- Extracts and sign/zero-extends sub-word load data (byte/half/word/double) using the address low bits.
- Holds the captured response in a 1-entry buffer while WB back-pressures.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- DEST_W, 5, register index width.
- ES_TO_MS_BUS_WD, 2+DEST_W+3+2*XLEN, derived; not overridable.
- MS_TO_WS_BUS_WD, 1+DEST_W+2*XLEN, derived; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MS can accept from EX
- es_to_ms_valid  in  1  EX offers an instruction
- es_to_ms_bus  in  ES_TO_MS_BUS_WD  fields, MSB first: res_from_mem(1), gr_we(1), dest(DEST_W), ld_op(3), alu_result(XLEN), pc(XLEN)
- ms_to_ws_valid  out  1  MS presents to WB
- ms_to_ws_bus  out  MS_TO_WS_BUS_WD  fields, MSB first: gr_we(1), dest(DEST_W), final_result(XLEN), pc(XLEN)
- data_rvalid  in  1  data memory response valid, single-cycle pulse
- data_rdata  in  XLEN  raw, XLEN-aligned response word

Behaviour:
- Reset (clk, reset synchronous, active-high): ms_valid=0, got_resp=0, ms_to_ws_valid=0, ms_allowin=1. Bus registers are not reset.
- Capture: on es_to_ms_valid && ms_allowin, register es_to_ms_bus.
  - On any accept, ms_valid <= es_to_ms_valid and got_resp <= 0.
- ms_ready_go = !res_from_mem || got_resp || data_rvalid. A response arriving in the same cycle passes through combinationally.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Response capture:
  - When ms_valid && res_from_mem && !got_resp && data_rvalid: resp_buf <= data_rdata and got_resp <= 1, unless the instruction leaves MS in the same cycle.
  - data_rvalid is ignored when there is no pending load (ms_valid=0, res_from_mem=0, or got_resp=1).
- Exactly one response per load; it may arrive at the earliest in the first cycle the load is valid in MS. Latency is unbounded and MS stalls indefinitely.
- Raw word = got_resp ? resp_buf : data_rdata. off = alu_result[2:0] for XLEN=64, alu_result[1:0] for XLEN=32.
- ld_op decode (byte lanes little-endian):
  - 000 LB: byte at off, sign-extended.
  - 001 LH: half at off[2:1], sign-extended.
  - 010 LW: word at off[2], sign-extended.
  - 011 LD: full word.
  - 100 LBU, 101 LHU, 110 LWU: same lanes, zero-extended.
  - 111: reserved, treated as LD.
- XLEN=32: LD/LWU/111 behave as full word; off[2] is treated as 0.
- Misaligned offsets within a lane are not checked; the lane index uses the truncated offset.
- final_result = res_from_mem ? extended load data : alu_result.
- Non-load instructions pass in 1 cycle, as in the single-cycle stage.
- Back-to-back loads: a new load may enter the cycle the previous one leaves. got_resp clears on accept, so no stale data is reused.
- WB stall after the response: resp_buf holds the data, ms_to_ws_valid stays 1 and the bus stays stable until ws_allowin.
- Reset mid-load: the pending load is dropped. A late data_rvalid arriving after reset with ms_valid=0 is ignored.

Optional Feature:
- Macro MEM_STAGE_FWD_EN.
- Defined: adds output ms_fwd_bus [2+DEST_W+XLEN-1:0] = {fwd_valid, fwd_ready, dest, final_result}.
  - fwd_valid = ms_valid && gr_we && dest!=0.
  - fwd_ready = ms_ready_go.
  - ID uses it for bypass or load-use stall.
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Shared header (mycpu.h): ld_op encodings LD_B..LD_WU, bus-width macros expressed in XLEN/DEST_W, and field-offset macros for es_to_ms_bus and ms_to_ws_bus.
- One sub-module, load_align: purely combinational (raw word, off, ld_op) -> extended data. It is reused later by a store-to-load bypass.

Test Plan:
- Non-load: ALU op with alu_result=0x1234, ws_allowin=1 -> ms_to_ws_valid the cycle after accept; final_result=0x1234.
- LB, off=3, rdata=0x0000_0000_8000_0000 with data_rvalid 4 cycles after entry -> valid stays 0 for 3 cycles, then final_result=0xFFFF_FFFF_FFFF_FF80; LBU of the same gives 0x80.
- LW, off=4, rdata=0x8765_4321_0000_0000, same-cycle rvalid, ws_allowin=0 for 3 cycles -> output held stable at 0xFFFF_FFFF_8765_4321; ms_allowin=0 until WB accepts.
- Back-to-back LD then LHU (off=6, rdata=0xBEEF_0000_0000_0000) -> second result 0xBEEF; the first load's data is not reused (got_resp cleared).
- Reset asserted while a load waits, then a stray data_rvalid -> ms_to_ws_valid stays 0, and the next non-load completes normally.
- With MEM_STAGE_FWD_EN defined, a pending load to x5 -> fwd_valid=1, fwd_ready=0 until rvalid; a load to x0 -> fwd_valid=0.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory stage: load-op encodings and bus-width helpers.
package mem_stage_lsu_pkg;

  typedef enum logic [2:0] {
    LD_B   = 3'b000,
    LD_H   = 3'b001,
    LD_W   = 3'b010,
    LD_D   = 3'b011,
    LD_BU  = 3'b100,
    LD_HU  = 3'b101,
    LD_WU  = 3'b110,
    LD_RSV = 3'b111
  } ld_op_e;

  localparam int LD_OP_W = 3;

  // EX->MS bus: res_from_mem, gr_we, dest, ld_op, alu_result, pc
  function automatic int es_bus_wd(input int xlen, input int dest_w);
    return 2 + dest_w + LD_OP_W + 2 * xlen;
  endfunction

  // MS->WB bus: gr_we, dest, final_result, pc
  function automatic int ms_bus_wd(input int xlen, input int dest_w);
    return 1 + dest_w + 2 * xlen;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load alignment: selects the addressed lane of a raw memory word
// and sign/zero-extends it to XLEN. Also intended for store-to-load bypass.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      off,
  input  logic [2:0]      ld_op,
  output logic [XLEN-1:0] data
);

  logic [2:0]  eff_off;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lane_w;

  // On a 32-bit datapath there is only one word lane, so off[2] is dropped.
  assign eff_off = (XLEN == 64) ? off : {1'b0, off[1:0]};
  assign lane_b  = raw[{eff_off, 3'b000} +: 8];
  assign lane_h  = raw[{eff_off[2:1], 4'b0000} +: 16];
  assign lane_w  = raw[{eff_off[2], 5'b00000} +: 32];

  always_comb begin
    data = raw;
    case (ld_op_e'(ld_op))
      LD_B:    data = XLEN'($signed(lane_b));
      LD_H:    data = XLEN'($signed(lane_h));
      LD_W:    data = XLEN'($signed(lane_w));
      LD_BU:   data = XLEN'(lane_b);
      LD_HU:   data = XLEN'(lane_h);
      LD_WU:   data = (XLEN == 64) ? XLEN'(lane_w) : raw;
      LD_D:    data = raw;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage with variable-latency load response and a 1-entry response buffer.
// Optional forwarding output enabled by defining MEM_STAGE_FWD_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter  int XLEN            = 64,
  parameter  int DEST_W          = 5,
  localparam int ES_TO_MS_BUS_WD = es_bus_wd(XLEN, DEST_W),
  localparam int MS_TO_WS_BUS_WD = ms_bus_wd(XLEN, DEST_W)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_rvalid,
  input  logic [XLEN-1:0]            data_rdata
`ifdef MEM_STAGE_FWD_EN
  ,
  output logic [2+DEST_W+XLEN-1:0]   ms_fwd_bus
`endif
);

  logic                       ms_valid;
  logic                       got_resp;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
  logic [XLEN-1:0]            resp_buf;

  logic                       res_from_mem;
  logic                       gr_we;
  logic [DEST_W-1:0]          dest;
  logic [2:0]                 ld_op;
  logic [XLEN-1:0]            alu_result;
  logic [XLEN-1:0]            pc;

  logic                       ms_ready_go;
  logic                       load_pending;
  logic [XLEN-1:0]            raw_word;
  logic [2:0]                 off;
  logic [XLEN-1:0]            load_data;
  logic [XLEN-1:0]            final_result;

  assign pc           = ms_bus[XLEN-1:0];
  assign alu_result   = ms_bus[2*XLEN-1:XLEN];
  assign ld_op        = ms_bus[2*XLEN+2:2*XLEN];
  assign dest         = ms_bus[2*XLEN+3 +: DEST_W];
  assign gr_we        = ms_bus[ES_TO_MS_BUS_WD-2];
  assign res_from_mem = ms_bus[ES_TO_MS_BUS_WD-1];

  // A same-cycle response passes straight through; later ones come from resp_buf.
  assign load_pending   = ms_valid && res_from_mem && !got_resp;
  assign ms_ready_go    = !res_from_mem || got_resp || data_rvalid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      got_resp <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      got_resp <= 1'b0;
    end else if (load_pending && data_rvalid) begin
      got_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus <= es_to_ms_bus;
    end
  end

  // Only buffer the response when WB is holding the load in MS.
  always_ff @(posedge clk) begin
    if (load_pending && data_rvalid && !ms_allowin) begin
      resp_buf <= data_rdata;
    end
  end

  assign raw_word = got_resp ? resp_buf : data_rdata;
  assign off      = (XLEN == 64) ? alu_result[2:0] : {1'b0, alu_result[1:0]};

  mem_stage_lsu_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .raw   (raw_word),
    .off   (off),
    .ld_op (ld_op),
    .data  (load_data)
  );

  assign final_result = res_from_mem ? load_data : alu_result;
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MEM_STAGE_FWD_EN
  assign ms_fwd_bus = {ms_valid && gr_we && (dest != {DEST_W{1'b0}}),
                       ms_ready_go, dest, final_result};
`endif

endmodule
